monitor_scan_sequencer: RTL and testbench

Sequences the ADC/DAC monitor mux across the eight converter tiles so that a downstream capture buffer can record every enabled tile in turn. For each enabled channel the block drives the monitor select lines and waits a fixed settle time for the registered monitor path. It then holds for a programmable dwell, and requests one capture through a req/ack handshake. It sits between the control register bank (start/stop/mask/dwell) and the monitor select inputs plus the capture buffer.

---
 rtl/monitor_scan_sequencer.sv | 154 +++++++++++++++
 tb/tb_monitor_scan_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/monitor_scan_sequencer.sv
// monitor_scan_sequencer
// Walks the ADC/DAC monitor mux over the enabled converter tiles. Each
// tile is settled, held for the dwell time, and then one capture is
// requested from the capture buffer.
module monitor_scan_sequencer #(
   parameter int NUM_CH        = 8,
   parameter int SETTLE_CYCLES = 2,
   parameter int DWELL_W       = 16
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [NUM_CH-1:0]  ch_mask,
   input  logic [DWELL_W-1:0] dwell_len,
   output logic [2:0]         adc_monitor_select,
   output logic [2:0]         dac_monitor_select,
   output logic               capture_req,
   input  logic               capture_ack,
   output logic               busy,
   output logic               done,
   output logic [2:0]         cur_ch,
   output logic [DWELL_W-1:0] scan_count,
   output logic               cfg_err
);

   typedef enum logic [1:0] {IDLE, SETTLE, DWELL, CAPTURE} state_t;

   localparam logic [DWELL_W-1:0] SETTLE_LAST = DWELL_W'(SETTLE_CYCLES - 1);

   state_t             state;
   logic [NUM_CH-1:0]  mask_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] dwell_last;
   logic [2:0]         first_ch;
   logic [2:0]         start_ch;
   logic [2:0]         next_ch;
   logic               next_vld;

   // Lowest enabled tile of a mask; callers guarantee the mask is non-zero.
   function automatic logic [2:0] lowest_set(input logic [NUM_CH-1:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i]) r = 3'(i);
      return r;
   endfunction

   // Selects always track the current channel register.
   assign adc_monitor_select = cur_ch;
   assign dac_monitor_select = cur_ch;

   // A zero dwell behaves like a one-cycle dwell.
   assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

   assign first_ch = lowest_set(mask_q);
   assign start_ch = lowest_set(ch_mask);

   // Priority search for the lowest enabled tile above the current one.
   always_comb begin
      next_ch  = '0;
      next_vld = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(cur_ch))) begin
            next_ch  = 3'(i);
            next_vld = 1'b1;
         end
      end
   end

   // Scan state machine with registered outputs; stop overrides everything.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         mask_q      <= '0;
         dwell_q     <= '0;
         cnt         <= '0;
         cur_ch      <= '0;
         capture_req <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         scan_count  <= '0;
         cfg_err     <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (stop) begin
            if (state != IDLE) begin
               state       <= IDLE;
               busy        <= 1'b0;
               capture_req <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (ch_mask == '0) begin
                        cfg_err <= 1'b1;
                     end else begin
                        mask_q  <= ch_mask;
                        dwell_q <= dwell_len;
                        cur_ch  <= start_ch;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SETTLE;
                     end
                  end
               end
               SETTLE: begin
                  if (cnt == SETTLE_LAST) begin
                     cnt   <= '0;
                     state <= DWELL;
                  end else begin
                     cnt <= cnt + DWELL_W'(1);
                  end
               end
               DWELL: begin
                  if (cnt == dwell_last) begin
                     cnt         <= '0;
                     capture_req <= 1'b1;
                     state       <= CAPTURE;
                  end else begin
                     cnt <= cnt + DWELL_W'(1);
                  end
               end
               CAPTURE: begin
                  if (capture_ack) begin
                     capture_req <= 1'b0;
                     cnt         <= '0;
                     if (next_vld) begin
                        cur_ch <= next_ch;
                        state  <= SETTLE;
                     end else begin
                        done <= 1'b1;
                        if (scan_count != '1) scan_count <= scan_count + DWELL_W'(1);
                        if (continuous) begin
                           cur_ch <= first_ch;
                           state  <= SETTLE;
                        end else begin
                           busy  <= 1'b0;
                           state <= IDLE;
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_monitor_scan_sequencer.sv
// Directed bench for monitor_scan_sequencer. Inputs are driven and outputs
// sampled on the falling edge; k counts rising edges since the start pulse.
module tb_monitor_scan_sequencer;

   localparam int NUM_CH  = 8;
   localparam int DWELL_W = 4;

   logic               clock = 1'b0;
   logic               resetn;
   logic               start, stop, continuous, capture_ack;
   logic [NUM_CH-1:0]  ch_mask;
   logic [DWELL_W-1:0] dwell_len;
   logic [2:0]         adc_monitor_select, dac_monitor_select, cur_ch;
   logic               capture_req, busy, done, cfg_err;
   logic [DWELL_W-1:0] scan_count;

   int n_chk = 0;
   int n_err = 0;
   int ndone;
   logic [31:0] exp_ch;

   monitor_scan_sequencer #(.NUM_CH(NUM_CH), .SETTLE_CYCLES(2), .DWELL_W(DWELL_W)) dut (
      .clock(clock), .resetn(resetn), .start(start), .stop(stop),
      .continuous(continuous), .ch_mask(ch_mask), .dwell_len(dwell_len),
      .adc_monitor_select(adc_monitor_select), .dac_monitor_select(dac_monitor_select),
      .capture_req(capture_req), .capture_ack(capture_ack), .busy(busy), .done(done),
      .cur_ch(cur_ch), .scan_count(scan_count), .cfg_err(cfg_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic rst();
      resetn = 1'b0; start = 1'b0; stop = 1'b0;
      @(negedge clock); @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      capture_ack = 1'b0; ch_mask = '0; dwell_len = '0;
      @(negedge clock);
      chk("rst_sel",  32'(adc_monitor_select), 32'd0);
      chk("rst_req",  32'(capture_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt",  32'(scan_count), 32'd0);
      chk("rst_err",  32'(cfg_err), 32'd0);

      // Single scan over tiles 2,5,7 with ack tied high.
      rst();
      ch_mask = 8'b1010_0100; dwell_len = 4'd3; continuous = 1'b0; capture_ack = 1'b1;
      pulse_start();
      for (int k = 1; k <= 20; k++) begin
         exp_ch = (k <= 6) ? 32'd2 : (k <= 12) ? 32'd5 : 32'd7;
         chk("t1_req",  32'(capture_req), 32'(k == 6 || k == 12 || k == 18));
         chk("t1_adc",  32'(adc_monitor_select), exp_ch);
         chk("t1_dac",  32'(dac_monitor_select), exp_ch);
         chk("t1_done", 32'(done), 32'(k == 19));
         chk("t1_busy", 32'(busy), 32'(k <= 18));
         @(negedge clock);
      end
      chk("t1_cnt",  32'(scan_count), 32'd1);
      chk("t1_hold", 32'(cur_ch), 32'd7);

      // Empty mask.
      rst();
      ch_mask = '0;
      pulse_start();
      chk("t2_err",  32'(cfg_err), 32'd1);
      chk("t2_busy", 32'(busy), 32'd0);
      chk("t2_sel",  32'(adc_monitor_select), 32'd0);
      @(negedge clock);
      chk("t2_err_pulse", 32'(cfg_err), 32'd0);
      chk("t2_busy2", 32'(busy), 32'd0);

      // One tile, continuous, zero dwell: done every 4 cycles.
      rst();
      ch_mask = 8'h01; dwell_len = 4'd0; continuous = 1'b1; capture_ack = 1'b1;
      pulse_start();
      for (int k = 1; k <= 21; k++) begin
         chk("t3_done", 32'(done), 32'(k >= 5 && ((k - 5) % 4) == 0));
         chk("t3_ch",   32'(cur_ch), 32'd0);
         @(negedge clock);
      end
      chk("t3_cnt", 32'(scan_count), 32'd5);
      stop = 1'b1; @(negedge clock); stop = 1'b0;
      chk("t3_stop", 32'(busy), 32'd0);

      // Ack withheld on tile 3 for 10 cycles.
      rst();
      ch_mask = 8'b0001_1000; dwell_len = 4'd1; continuous = 1'b0; capture_ack = 1'b0;
      pulse_start();
      repeat (3) @(negedge clock);
      for (int k = 4; k <= 13; k++) begin
         chk("t4_req_hold", 32'(capture_req), 32'd1);
         chk("t4_ch_hold",  32'(cur_ch), 32'd3);
         if (k == 13) capture_ack = 1'b1;
         @(negedge clock);
      end
      chk("t4_req_drop", 32'(capture_req), 32'd0);
      chk("t4_next_ch",  32'(cur_ch), 32'd4);
      repeat (3) @(negedge clock);
      chk("t4_req4", 32'(capture_req), 32'd1);
      @(negedge clock);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_cnt",  32'(scan_count), 32'd1);

      // Stop (with a simultaneous start) during the dwell of tile 4.
      rst();
      ch_mask = 8'b0001_1000; dwell_len = 4'd5; continuous = 1'b1; capture_ack = 1'b1;
      pulse_start();
      repeat (11) @(negedge clock);
      chk("t5_pre_ch",  32'(cur_ch), 32'd4);
      chk("t5_pre_req", 32'(capture_req), 32'd0);
      stop = 1'b1; start = 1'b1;
      @(negedge clock);
      stop = 1'b0; start = 1'b0;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_cnt",  32'(scan_count), 32'd0);
      chk("t5_ch",   32'(cur_ch), 32'd4);
      for (int k = 0; k < 8; k++) begin
         chk("t5_req_idle",  32'(capture_req), 32'd0);
         chk("t5_done_idle", 32'(done), 32'd0);
         chk("t5_busy_idle", 32'(busy), 32'd0);
         @(negedge clock);
      end

      // Asynchronous reset while a capture is pending.
      rst();
      ch_mask = 8'h08; dwell_len = 4'd1; continuous = 1'b0; capture_ack = 1'b0;
      pulse_start();
      repeat (3) @(negedge clock);
      chk("t6_req_pre", 32'(capture_req), 32'd1);
      chk("t6_sel_pre", 32'(adc_monitor_select), 32'd3);
      #2 resetn = 1'b0;
      #1;
      chk("t6_req", 32'(capture_req), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_sel", 32'(adc_monitor_select), 32'd0);
      chk("t6_dac", 32'(dac_monitor_select), 32'd0);
      @(negedge clock);
      resetn = 1'b1;

      // scan_count saturates at all-ones (15 for a 4-bit counter).
      rst();
      ch_mask = 8'h01; dwell_len = 4'd0; continuous = 1'b1; capture_ack = 1'b1;
      ndone = 0;
      pulse_start();
      for (int k = 1; k <= 90; k++) begin
         if (done) ndone++;
         if (k == 57) chk("t7_cnt14", 32'(scan_count), 32'd14);
         if (k == 61) chk("t7_cnt15", 32'(scan_count), 32'd15);
         @(negedge clock);
      end
      chk("t7_ndone", 32'(ndone), 32'd22);
      chk("t7_sat",   32'(scan_count), 32'd15);
      stop = 1'b1; @(negedge clock); stop = 1'b0;
      chk("t7_stop", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
